tb_aggregator: RTL
==================

TB_AGGREGATOR -- requirements
Module: tb_aggregator

Interface
REQ-001 Parameter DATA_WIDTH, default 4: width of one sample word.
REQ-002 Parameter DEPTH, default 64: words per frame; SHALL be a power of two >= 2.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_data  input  DATA_WIDTH  streamed sample word.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block can accept a word; transfer when in_valid && in_ready.
REQ-008 flush  input  1  close current partial frame early.
REQ-009 out_data  output  DATA_WIDTH x DEPTH unpacked array  completed frame, entry i = i-th word accepted.
REQ-010 out_count  output  log2(DEPTH)+1  number of valid words in out_data (1..DEPTH).
REQ-011 out_valid  output  1  out_data/out_count hold a completed frame.
REQ-012 out_ready  input  1  downstream transpose stage takes frame; handoff when out_valid && out_ready.

Function
REQ-013 Storage SHALL be two banks (ping-pong) of DEPTH words; each bank has state EMPTY, FILLING or FULL.
REQ-014 Exactly one bank SHALL be the write bank; word i of a frame SHALL be written to entry wr_ptr, then wr_ptr increments.
REQ-015 in_ready SHALL be 1 iff the write bank is EMPTY or FILLING; combinational from registered state only.
REQ-016 Accepting a word when wr_ptr == DEPTH-1 SHALL mark the bank FULL with count DEPTH, reset wr_ptr to 0 and switch the write bank to the other bank (wrap-around).
REQ-017 flush with wr_ptr > 0 SHALL mark the write bank FULL with count = wr_ptr (plus 1 if a word is accepted the same cycle) and switch banks; flush with wr_ptr == 0 and no accepted word SHALL be ignored.
REQ-018 Word accepted and flush in the same cycle: the word SHALL be included in the closed frame.
REQ-019 Unwritten entries of a flushed frame SHALL read as zero (bank cleared when it becomes EMPTY).
REQ-020 Frames SHALL be presented in completion order; read bank = oldest FULL bank.
REQ-021 out_valid SHALL be registered; latency from the accepting edge of a frame's last word to out_valid = 1 SHALL be exactly one cycle when the read side is idle.
REQ-022 out_data and out_count SHALL be stable while out_valid && !out_ready.
REQ-023 On handoff the read bank SHALL return to EMPTY next cycle; if the other bank is FULL, out_valid SHALL remain 1 with the new frame (back-to-back, no bubble).
REQ-024 Both banks FULL: in_ready = 0 until a handoff; an accept in the handoff cycle is not permitted (in_ready reflects pre-handoff state).
REQ-025 out_count arithmetic SHALL be unsigned, width log2(DEPTH)+1, no truncation at DEPTH.

Reset
REQ-026 On rst_n low, immediately: both banks EMPTY, write bank = bank 0, wr_ptr = 0, out_valid = 0, out_count = 0, in_ready = 1 after deassertion, out_data all zero.
REQ-027 Reset mid-frame SHALL discard all partial and completed frames; no frame is emitted for pre-reset data.

Structure
REQ-028 Shared package SHALL hold bank-state enum (EMPTY/FILLING/FULL), DATA_WIDTH/DEPTH defaults and the count width function.
REQ-029 One sub-module tb_agg_bank (one DEPTH-entry bank: write port, clear, state, count) SHALL be instantiated twice.
REQ-030 Implementation SHALL be synthesizable, no latches, single clock domain.

Verification
REQ-031 Stream 64 words 0..63 (mod 16) continuously, out_ready = 1 -> one frame, out_count = 64, out_data[i] = i mod 16, out_valid 1 cycle after 64th accept.
REQ-032 Stream 128 words, out_ready = 0 -> in_ready drops after word 128; assert out_ready -> two frames in order, back-to-back, in_ready returns 1.
REQ-033 Send 5 words, flush with 6th word same cycle -> out_count = 6, entries 6..63 zero.
REQ-034 flush with no words pending -> no frame, state unchanged.
REQ-035 Assert rst_n low after 30 words of a frame -> out_valid = 0, in_ready = 1, next 64 words form a clean frame starting at entry 0.
REQ-036 Random in_valid/out_ready backpressure, 1000 words -> scoreboard sees every word exactly once, in order.

Source files
------------

// File: rtl/tb_aggregator_pkg.sv
// rtl/tb_aggregator_pkg.sv - shared types and sizing helpers for the ping-pong frame aggregator
package tb_aggregator_pkg;

    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_DEPTH      = 64;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Frame counts run 1..DEPTH, so one extra bit over the address width.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/tb_agg_bank.sv
// rtl/tb_agg_bank.sv - one DEPTH-entry frame bank with write port, close, clear, state and count
module tb_agg_bank
    import tb_aggregator_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  DEPTH      = DEF_DEPTH,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  close_en,
    input  logic [CW-1:0]         close_count,
    input  logic                  clear,
    output logic [1:0]            state,
    output logic [CW-1:0]         count,
    output logic [DATA_WIDTH-1:0] rd_data [DEPTH]
);

    bank_state_e           state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Next bank contents/state: clear wipes the bank so short frames read back zero-padded.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (clear) begin
            state_d = BANK_EMPTY;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else begin
            if (wr_en) begin
                mem_d[wr_addr] = wr_data;
                state_d        = BANK_FILLING;
            end
            if (close_en) begin
                state_d = BANK_FULL;
                count_d = close_count;
            end
        end
    end

    // Bank register file and state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BANK_EMPTY;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign state   = state_q;
    assign count   = count_q;
    assign rd_data = mem_q;

endmodule

// File: rtl/tb_aggregator.sv
// rtl/tb_aggregator.sv - streams words into ping-pong banks and presents completed frames in order
module tb_aggregator
    import tb_aggregator_pkg::*;
#(
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  DEPTH      = DEF_DEPTH,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] out_data [DEPTH],
    output logic [CW-1:0]         out_count,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          out_valid_q, out_valid_d;

    logic [1:0]            bank0_state, bank1_state;
    logic [CW-1:0]         bank0_count, bank1_count;
    logic [DATA_WIDTH-1:0] bank0_data [DEPTH];
    logic [DATA_WIDTH-1:0] bank1_data [DEPTH];

    logic [1:0]    bank_full;
    logic [1:0]    bank_wr_en;
    logic [1:0]    bank_close;
    logic [1:0]    bank_clear;
    logic          accept;
    logic          close_frame;
    logic          handoff;
    logic [CW-1:0] close_count;

    assign bank_full[0] = (bank0_state == BANK_FULL);
    assign bank_full[1] = (bank1_state == BANK_FULL);

    // The write bank is only ever FULL when both banks hold unread frames.
    assign in_ready = !bank_full[wr_bank_q];
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid_q && out_ready;

    // Frame closes on the last word of a bank or on a flush that has something to close.
    assign close_frame = (accept && (wr_ptr_q == AW'(DEPTH - 1)))
                       || (flush && ((wr_ptr_q != '0) || accept));
    assign close_count = {1'b0, wr_ptr_q} + CW'(accept);

    // Steer write, close and clear strobes to the bank they belong to.
    always_comb begin
        bank_wr_en             = '0;
        bank_close             = '0;
        bank_clear             = '0;
        bank_wr_en[wr_bank_q]  = accept;
        bank_close[wr_bank_q]  = close_frame;
        bank_clear[rd_bank_q]  = handoff;
    end

    // Write pointer and bank rotation; read bank follows the same alternation so order is kept.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (close_frame) begin
            wr_ptr_d  = '0;
            wr_bank_d = !wr_bank_q;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (handoff) begin
            rd_bank_d = !rd_bank_q;
        end
    end

    // out_valid looks ahead to the read bank's state after this edge, giving one-cycle latency and no bubble.
    always_comb begin
        out_valid_d = bank_full[rd_bank_q] || bank_close[rd_bank_q];
        if (handoff) begin
            out_valid_d = bank_full[!rd_bank_q] || bank_close[!rd_bank_q];
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            out_valid_q <= out_valid_d;
        end
    end

    tb_agg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (bank_wr_en[0]),
        .wr_addr     (wr_ptr_q),
        .wr_data     (in_data),
        .close_en    (bank_close[0]),
        .close_count (close_count),
        .clear       (bank_clear[0]),
        .state       (bank0_state),
        .count       (bank0_count),
        .rd_data     (bank0_data)
    );

    tb_agg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (bank_wr_en[1]),
        .wr_addr     (wr_ptr_q),
        .wr_data     (in_data),
        .close_en    (bank_close[1]),
        .close_count (close_count),
        .clear       (bank_clear[1]),
        .state       (bank1_state),
        .count       (bank1_count),
        .rd_data     (bank1_data)
    );

    // Present the read bank only while a frame is offered; otherwise outputs sit at zero.
    always_comb begin
        out_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            out_data[i] = '0;
        end
        if (out_valid_q) begin
            out_count = rd_bank_q ? bank1_count : bank0_count;
            for (int i = 0; i < DEPTH; i++) begin
                out_data[i] = rd_bank_q ? bank1_data[i] : bank0_data[i];
            end
        end
    end

    assign out_valid = out_valid_q;

endmodule
